// File: rtl/mem_port_arbiter.sv
// Two-master arbiter in front of single-port Memory32: fixed priority with m1 starvation guard, or round-robin.
// Latency: grant and memory request same cycle; rvalid/rdata one cycle after accept (reads and write acks).
// Backpressure: a denied master sees ready=0 and must hold valid and attributes until granted.
`timescale 1ns/1ps
module mem_port_arbiter #(
    parameter bit          FIXED_PRIO = 1'b1,
    parameter int unsigned MAX_WAIT   = 15
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        m0_valid,
    input  logic        m0_write,
    input  logic [3:0]  m0_wmask,
    input  logic [31:0] m0_wdata,
    input  logic        m0_wgrubby,
    input  logic [31:0] m0_addr,
    output logic        m0_ready,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    output logic        m0_rgrubby,
    input  logic        m1_valid,
    input  logic        m1_write,
    input  logic [3:0]  m1_wmask,
    input  logic [31:0] m1_wdata,
    input  logic        m1_wgrubby,
    input  logic [31:0] m1_addr,
    output logic        m1_ready,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic        m1_rgrubby,
    output logic        mem_valid,
    output logic        mem_write,
    output logic [3:0]  mem_wmask,
    output logic [31:0] mem_wdata,
    output logic        mem_wgrubby,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rgrubby
);

    typedef struct packed {
        logic        write;
        logic [3:0]  wmask;
        logic [31:0] wdata;
        logic        wgrubby;
        logic [31:0] addr;
    } req_t;

    localparam logic [7:0] WAIT_MAX = 8'(MAX_WAIT);

    req_t       m0_req, m1_req, gnt_req;
    logic       any_vld;
    logic       gnt;      // 0: master 0, 1: master 1
    logic       q_last;
    logic       q_rsel;
    logic       q_rpend;
    logic [7:0] q_wait;

    assign m0_req  = '{write: m0_write, wmask: m0_wmask, wdata: m0_wdata, wgrubby: m0_wgrubby, addr: m0_addr};
    assign m1_req  = '{write: m1_write, wmask: m1_wmask, wdata: m1_wdata, wgrubby: m1_wgrubby, addr: m1_addr};
    assign any_vld = m0_valid | m1_valid;

    always_comb begin
        gnt = 1'b0;
        if (m1_valid && !m0_valid) begin
            gnt = 1'b1;
        end else if (m0_valid && m1_valid) begin
            gnt = FIXED_PRIO ? (q_wait == WAIT_MAX) : ~q_last;
        end
    end

    // Everything facing the masters and the memory is held quiet while reset is asserted.
    assign m0_ready  = rstn & m0_valid & ~gnt;
    assign m1_ready  = rstn & m1_valid & gnt;
    assign mem_valid = rstn & any_vld;

    always_comb begin
        gnt_req = '0;
        if (mem_valid) begin
            gnt_req = gnt ? m1_req : m0_req;
        end
    end

    assign mem_write   = gnt_req.write;
    assign mem_wmask   = gnt_req.wmask;
    assign mem_wdata   = gnt_req.wdata;
    assign mem_wgrubby = gnt_req.wgrubby;
    assign mem_addr    = gnt_req.addr;

    assign m0_rvalid  = q_rpend & ~q_rsel;
    assign m1_rvalid  = q_rpend & q_rsel;
    assign m0_rdata   = m0_rvalid ? mem_rdata : '0;
    assign m1_rdata   = m1_rvalid ? mem_rdata : '0;
    assign m0_rgrubby = m0_rvalid & mem_rgrubby;
    assign m1_rgrubby = m1_rvalid & mem_rgrubby;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q_last  <= 1'b1;
            q_wait  <= '0;
            q_rpend <= 1'b0;
            q_rsel  <= 1'b0;
        end else begin
            q_rpend <= any_vld;
            if (any_vld) begin
                q_rsel <= gnt;
                q_last <= gnt;
            end
            // Starvation counter: only a denied, still-requesting m1 advances it.
            if (FIXED_PRIO && m1_valid && !gnt) begin
                q_wait <= (q_wait == WAIT_MAX) ? q_wait : q_wait + 8'd1;
            end else begin
                q_wait <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: dut 0 is fixed priority (MAX_WAIT=3), dut 1 is round-robin; each has its own memory.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    typedef struct packed {
        logic        write;
        logic [3:0]  wmask;
        logic [31:0] wdata;
        logic        wgrubby;
        logic [31:0] addr;
    } req_t;

    typedef struct {
        int          m;
        bit          rd;
        logic [31:0] data;
        logic        grub;
        int          due;
    } rsp_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic        mv[2][2], mw[2][2], mwg[2][2], mrdy[2][2], mrv[2][2], mrg[2][2];
    logic [3:0]  mwm[2][2];
    logic [31:0] mwd[2][2], ma[2][2], mrd[2][2];
    logic        xv[2], xw[2], xwg[2], xrg[2];
    logic [3:0]  xwm[2];
    logic [31:0] xwd[2], xa[2], xrd[2];

    mem_port_arbiter #(.FIXED_PRIO(1'b1), .MAX_WAIT(3)) u_fp (
        .clk(clk), .rstn(rstn),
        .m0_valid(mv[0][0]), .m0_write(mw[0][0]), .m0_wmask(mwm[0][0]), .m0_wdata(mwd[0][0]),
        .m0_wgrubby(mwg[0][0]), .m0_addr(ma[0][0]), .m0_ready(mrdy[0][0]), .m0_rvalid(mrv[0][0]),
        .m0_rdata(mrd[0][0]), .m0_rgrubby(mrg[0][0]),
        .m1_valid(mv[0][1]), .m1_write(mw[0][1]), .m1_wmask(mwm[0][1]), .m1_wdata(mwd[0][1]),
        .m1_wgrubby(mwg[0][1]), .m1_addr(ma[0][1]), .m1_ready(mrdy[0][1]), .m1_rvalid(mrv[0][1]),
        .m1_rdata(mrd[0][1]), .m1_rgrubby(mrg[0][1]),
        .mem_valid(xv[0]), .mem_write(xw[0]), .mem_wmask(xwm[0]), .mem_wdata(xwd[0]),
        .mem_wgrubby(xwg[0]), .mem_addr(xa[0]), .mem_rdata(xrd[0]), .mem_rgrubby(xrg[0])
    );

    mem_port_arbiter #(.FIXED_PRIO(1'b0), .MAX_WAIT(15)) u_rr (
        .clk(clk), .rstn(rstn),
        .m0_valid(mv[1][0]), .m0_write(mw[1][0]), .m0_wmask(mwm[1][0]), .m0_wdata(mwd[1][0]),
        .m0_wgrubby(mwg[1][0]), .m0_addr(ma[1][0]), .m0_ready(mrdy[1][0]), .m0_rvalid(mrv[1][0]),
        .m0_rdata(mrd[1][0]), .m0_rgrubby(mrg[1][0]),
        .m1_valid(mv[1][1]), .m1_write(mw[1][1]), .m1_wmask(mwm[1][1]), .m1_wdata(mwd[1][1]),
        .m1_wgrubby(mwg[1][1]), .m1_addr(ma[1][1]), .m1_ready(mrdy[1][1]), .m1_rvalid(mrv[1][1]),
        .m1_rdata(mrd[1][1]), .m1_rgrubby(mrg[1][1]),
        .mem_valid(xv[1]), .mem_write(xw[1]), .mem_wmask(xwm[1]), .mem_wdata(xwd[1]),
        .mem_wgrubby(xwg[1]), .mem_addr(xa[1]), .mem_rdata(xrd[1]), .mem_rgrubby(xrg[1])
    );

    function automatic logic [31:0] init_word(input int i);
        return (i == 64) ? 32'hDEADBEEF : (32'h5A000000 ^ (i * 32'h00010203));
    endfunction

    // Memory32 stand-in: synchronous, read data one cycle after the request.
    logic [31:0] envmem[2][256];
    logic        envg[2][256];
    bit          env_init = 0;
    always @(posedge clk) begin
        if (!env_init) begin
            for (int d = 0; d < 2; d++)
                for (int i = 0; i < 256; i++) begin
                    envmem[d][i] <= init_word(i);
                    envg[d][i]   <= i[0];
                end
            env_init <= 1;
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (xv[d]) begin
                    if (xw[d]) begin
                        for (int b = 0; b < 4; b++)
                            if (xwm[d][b]) envmem[d][xa[d][9:2]][8*b +: 8] <= xwd[d][8*b +: 8];
                        envg[d][xa[d][9:2]] <= xwg[d];
                    end
                    xrd[d] <= envmem[d][xa[d][9:2]];
                    xrg[d] <= envg[d][xa[d][9:2]];
                end
            end
        end
    end

    // Reference model, scoreboard and monitor; sole owner of the comparison counters.
    int          nvec = 0, nerr = 0, cyc = 0;
    int          last[2], waitc[2], patk[2];
    int          acc_cnt[2][2];
    rsp_t        sb[2][$];
    logic [31:0] refmem[2][256];
    logic        refg[2][256];
    bit          ref_init = 0, to_done = 0, fin_done = 0;
    bit          to_flag = 0, fin_req = 0;
    bit          pat_mode[2];

    task automatic chk(input string nm, input int d, input logic [31:0] a, input logic [31:0] e);
        nvec++;
        if (a !== e) begin
            nerr++;
            $display("FAIL %s dut%0d cyc%0d: got %h expected %h", nm, d, cyc, a, e);
        end
    endtask

    always @(negedge clk) begin
        logic v0, v1, g, ep, exp_rv;
        logic [7:0] ix;
        if (!ref_init) begin
            for (int d = 0; d < 2; d++) begin
                for (int i = 0; i < 256; i++) begin
                    refmem[d][i] = init_word(i);
                    refg[d][i]   = i[0];
                end
                acc_cnt[d][0] = 0;
                acc_cnt[d][1] = 0;
            end
            ref_init = 1;
        end
        cyc++;
        if (to_flag && !to_done) begin
            chk("drain_timeout", 0, 32'd1, 32'd0);
            to_done = 1;
        end
        for (int d = 0; d < 2; d++) begin
            if (fin_req && !fin_done) chk("sb_empty_at_end", d, 32'(sb[d].size()), 32'd0);
            if (!rstn) begin
                sb[d].delete();
                last[d] = 1; waitc[d] = 0; patk[d] = 0;
                chk("rst_ready0", d, 32'(mrdy[d][0]), 32'd0);
                chk("rst_ready1", d, 32'(mrdy[d][1]), 32'd0);
                chk("rst_rvalid0", d, 32'(mrv[d][0]), 32'd0);
                chk("rst_rvalid1", d, 32'(mrv[d][1]), 32'd0);
                chk("rst_mem_valid", d, 32'(xv[d]), 32'd0);
                continue;
            end
            for (int m = 0; m < 2; m++) begin
                exp_rv = (sb[d].size() > 0) && (sb[d][0].due == cyc) && (sb[d][0].m == m);
                chk("rvalid", d, 32'(mrv[d][m]), 32'(exp_rv));
                if (exp_rv && sb[d][0].rd) begin
                    chk("rdata", d, mrd[d][m], sb[d][0].data);
                    chk("rgrubby", d, 32'(mrg[d][m]), 32'(sb[d][0].grub));
                end else if (!exp_rv) begin
                    chk("rdata_idle", d, mrd[d][m], 32'd0);
                end
            end
            if (sb[d].size() > 0 && sb[d][0].due == cyc) void'(sb[d].pop_front());

            v0 = mv[d][0];
            v1 = mv[d][1];
            if (v0 && v1)
                g = (d == 0) ? (waitc[d] == 3) : (last[d] == 0);
            else
                g = v1;
            if (v0 && v1 && pat_mode[d]) begin
                ep = (d == 0) ? ((patk[d] % 4) == 3) : ((patk[d] % 2) == 1);
                chk("tie_pattern_m1_ready", d, 32'(mrdy[d][1]), 32'(ep));
                patk[d]++;
            end
            if (!pat_mode[d]) patk[d] = 0;
            chk("ready0", d, 32'(mrdy[d][0]), 32'(v0 && !g));
            chk("ready1", d, 32'(mrdy[d][1]), 32'(v1 && g));
            chk("mem_valid", d, 32'(xv[d]), 32'(v0 || v1));
            if (v0 || v1) begin
                chk("mem_addr", d, xa[d], ma[d][g]);
                chk("mem_write", d, 32'(xw[d]), 32'(mw[d][g]));
                if (mw[d][g]) begin
                    chk("mem_wdata", d, xwd[d], mwd[d][g]);
                    chk("mem_wmask", d, 32'(xwm[d]), 32'(mwm[d][g]));
                end
                ix = ma[d][g][9:2];
                sb[d].push_back('{m: int'(g), rd: !mw[d][g], data: refmem[d][ix], grub: refg[d][ix], due: cyc + 1});
                if (mw[d][g]) begin
                    for (int b = 0; b < 4; b++)
                        if (mwm[d][g][b]) refmem[d][ix][8*b +: 8] = mwd[d][g][8*b +: 8];
                    refg[d][ix] = mwg[d][g];
                end
                last[d] = int'(g);
                acc_cnt[d][g]++;
            end else begin
                chk("mem_addr_idle", d, xa[d], 32'd0);
            end
            if (v1 && !g) waitc[d] = (waitc[d] == 3) ? 3 : waitc[d] + 1;
            else          waitc[d] = 0;
        end
        if (fin_req) fin_done = 1;
    end

    // Stimulus: per-master request queues, each held on the bus until accepted.
    req_t req_q[2][2][$];
    bit   act[2][2];
    int   seen[2][2];
    bit   gap_en = 0;

    task automatic drive_bus();
        req_t r;
        for (int d = 0; d < 2; d++)
            for (int m = 0; m < 2; m++) begin
                r = act[d][m] ? req_q[d][m][0] : '0;
                mv[d][m]  = act[d][m];
                mw[d][m]  = r.write;
                mwm[d][m] = r.wmask;
                mwd[d][m] = r.wdata;
                mwg[d][m] = r.wgrubby;
                ma[d][m]  = r.addr;
            end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++)
            for (int m = 0; m < 2; m++) begin
                if (acc_cnt[d][m] != seen[d][m]) begin
                    seen[d][m] = acc_cnt[d][m];
                    if (req_q[d][m].size() > 0) void'(req_q[d][m].pop_front());
                    act[d][m] = 0;
                end
                if (!act[d][m] && req_q[d][m].size() > 0 && (!gap_en || $urandom_range(0, 3) != 0))
                    act[d][m] = 1;
            end
        drive_bus();
    endtask

    task automatic flush_stim();
        for (int d = 0; d < 2; d++)
            for (int m = 0; m < 2; m++) begin
                req_q[d][m].delete();
                act[d][m]  = 0;
                seen[d][m] = acc_cnt[d][m];
            end
        drive_bus();
    endtask

    function automatic bit busy();
        for (int d = 0; d < 2; d++)
            for (int m = 0; m < 2; m++)
                if (act[d][m] || req_q[d][m].size() > 0) return 1;
        return 0;
    endfunction

    task automatic run_all(input int budget);
        int n = 0;
        while (busy() && n < budget) begin
            step();
            n++;
        end
        if (busy()) begin
            to_flag = 1;
            flush_stim();
        end
        repeat (2) step();
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        flush_stim();
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    function automatic req_t rd_req(input logic [31:0] a);
        return '{write: 1'b0, wmask: 4'h0, wdata: 32'h0, wgrubby: 1'b0, addr: a};
    endfunction

    function automatic req_t rnd_req();
        req_t r;
        r.write   = 1'($urandom_range(0, 1));
        r.wmask   = 4'($urandom_range(0, 15));
        r.wdata   = $urandom;
        r.wgrubby = 1'($urandom_range(0, 1));
        r.addr    = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
        return r;
    endfunction

    initial begin
        pat_mode[0] = 0;
        pat_mode[1] = 0;
        flush_stim();
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;

        // Single m0 read of the preloaded word; round-robin dut alternates from reset.
        req_q[0][0].push_back(rd_req(32'h100));
        for (int i = 0; i < 6; i++) begin
            req_q[1][0].push_back(rd_req(32'(i * 8)));
            req_q[1][1].push_back(rd_req(32'(i * 8 + 4)));
        end
        pat_mode[1] = 1;
        run_all(100);
        pat_mode[1] = 0;

        // Fixed priority with continuous contention: m1 every fourth grant.
        for (int i = 0; i < 20; i++) req_q[0][0].push_back(rd_req(32'(i * 4)));
        for (int i = 0; i < 4; i++)  req_q[0][1].push_back(rd_req(32'(i * 4 + 512)));
        pat_mode[0] = 1;
        run_all(100);
        pat_mode[0] = 0;

        // Partial write from m1 followed immediately by an m0 read of the same word.
        req_q[0][1].push_back('{write: 1'b1, wmask: 4'b0011, wdata: 32'h12345678, wgrubby: 1'b0, addr: 32'h40});
        step();
        req_q[0][0].push_back(rd_req(32'h40));
        run_all(50);

        // Reset lands while an m0 read response is in flight and m1 has been waiting.
        req_q[0][0].push_back(rd_req(32'h100));
        req_q[0][0].push_back(rd_req(32'h104));
        req_q[0][1].push_back(rd_req(32'h108));
        repeat (3) step();
        do_reset();
        for (int i = 0; i < 8; i++) req_q[0][0].push_back(rd_req(32'(i * 4)));
        for (int i = 0; i < 2; i++) req_q[0][1].push_back(rd_req(32'(i * 4 + 64)));
        pat_mode[0] = 1;
        run_all(100);
        pat_mode[0] = 0;

        // Idle stretch must not disturb round-robin history: m0 last, so m1 wins the next tie.
        req_q[1][0].push_back(rd_req(32'h20));
        run_all(50);
        repeat (10) step();
        req_q[1][0].push_back(rd_req(32'h24));
        req_q[1][1].push_back(rd_req(32'h28));
        run_all(50);

        // Random mixed traffic with gaps on both duts.
        gap_en = 1;
        for (int d = 0; d < 2; d++)
            for (int m = 0; m < 2; m++)
                for (int i = 0; i < 150; i++) req_q[d][m].push_back(rnd_req());
        run_all(4000);
        gap_en = 0;

        repeat (3) step();
        fin_req = 1;
        repeat (2) step();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
